// File: rtl/fmul_pkg.sv
// Shared definitions for the shared floating-point multiplier arbiter:
// FSM state encodings and the default abort timeout.
package fmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int WORD_W          = 32;

endpackage

// File: rtl/fmul_share_arb_rr_pick.sv
// Combinational round-robin pick: rotate requests so ptr lands at bit 0,
// find the lowest set bit, then rotate the index back into requester space.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   gnt_id
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   rot;
  logic [IW-1:0]     off;
  logic [IW:0]       sum;

  assign req_dbl = {req, req};

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
      assign rot[gi] = req_dbl[gi + int'(ptr)];
    end
  endgenerate

  // Scan from the top so the lowest set bit is the one that sticks.
  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
  end

  assign valid  = |req;
  assign sum    = {1'b0, off} + {1'b0, ptr};
  assign gnt_id = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];

endmodule

// File: rtl/fmul_share_arb.sv
// Round-robin arbiter that time-shares one external FP multiplier between
// NREQ requesters, with a per-operation abort timeout.
module fmul_share_arb
  import fmul_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          rsp_result,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  output logic                 mul_start,
  input  logic [3:0]           mul_done,
  input  logic [31:0]          mul_result
);

  localparam int IW = $clog2(NREQ);

  state_e              state_reg, state_next;
  logic [IW-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]       cur_id_reg, cur_id_next;
  logic [15:0]         timer_reg, timer_next;
  logic [NREQ-1:0]     ack_reg, ack_next;
  logic [WORD_W-1:0]   rsp_result_reg, rsp_result_next;
  logic                rsp_err_reg, rsp_err_next;
  logic                mul_start_reg, mul_start_next;
  logic [WORD_W-1:0]   mul_a_reg, mul_a_next;
  logic [WORD_W-1:0]   mul_b_reg, mul_b_next;

  logic                pick_valid;
  logic [IW-1:0]       pick_id;
  logic                timer_hit;
  logic [IW-1:0]       id_inc;
  logic                unused_done;

  // Only bit 0 of the multiplier's done bus carries meaning.
  assign unused_done = ^mul_done[3:1];

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr_reg),
    .valid  (pick_valid),
    .gnt_id (pick_id)
  );

  assign timer_hit = ({1'b0, timer_reg} + 17'd1) >= 17'(TIMEOUT);
  assign id_inc    = (cur_id_reg == IW'(NREQ - 1)) ? '0 : cur_id_reg + IW'(1);

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    cur_id_next     = cur_id_reg;
    timer_next      = timer_reg;
    ack_next        = '0;
    rsp_result_next = rsp_result_reg;
    rsp_err_next    = rsp_err_reg;
    mul_start_next  = mul_start_reg;
    mul_a_next      = mul_a_reg;
    mul_b_next      = mul_b_reg;

    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next     = ST_BUSY;
          cur_id_next    = pick_id;
          mul_a_next     = req_a[32*int'(pick_id) +: 32];
          mul_b_next     = req_b[32*int'(pick_id) +: 32];
          mul_start_next = 1'b1;
          timer_next     = '0;
        end
      end
      ST_BUSY: begin
        timer_next = timer_reg + 16'd1;
        // Done is checked first so it wins over a same-cycle timeout.
        if (mul_done[0] || timer_hit) begin
          state_next     = ST_RELEASE;
          ack_next       = NREQ'(1) << cur_id_reg;
          mul_start_next = 1'b0;
          rr_ptr_next    = id_inc;
          rsp_err_next   = !mul_done[0];
          if (mul_done[0]) rsp_result_next = mul_result;
        end
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      rr_ptr_reg     <= '0;
      cur_id_reg     <= '0;
      timer_reg      <= '0;
      ack_reg        <= '0;
      rsp_result_reg <= '0;
      rsp_err_reg    <= 1'b0;
      mul_start_reg  <= 1'b0;
      mul_a_reg      <= '0;
      mul_b_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      cur_id_reg     <= cur_id_next;
      timer_reg      <= timer_next;
      ack_reg        <= ack_next;
      rsp_result_reg <= rsp_result_next;
      rsp_err_reg    <= rsp_err_next;
      mul_start_reg  <= mul_start_next;
      mul_a_reg      <= mul_a_next;
      mul_b_reg      <= mul_b_next;
    end
  end

  assign ack        = ack_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_err    = rsp_err_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign mul_a      = mul_a_reg;
  assign mul_b      = mul_b_reg;
  assign mul_start  = mul_start_reg;

endmodule

// File: tb/tb_fmul_share_arb.sv
// Bench for fmul_share_arb: requester and multiplier models plus a
// round-robin reference that predicts ack order and results.
module tb_fmul_share_arb;

  localparam int NREQ = 4;
  localparam int TMO  = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*32-1:0]  req_a = '0;
  logic [NREQ*32-1:0]  req_b = '0;
  logic [NREQ-1:0]     ack;
  logic [31:0]         rsp_result;
  logic                rsp_err;
  logic                busy;
  logic [31:0]         mul_a;
  logic [31:0]         mul_b;
  logic                mul_start;
  logic [3:0]          mul_done = '0;
  logic [31:0]         mul_result;

  always #5 clk = ~clk;

  fmul_share_arb #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .ack        (ack),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_start  (mul_start),
    .mul_done   (mul_done),
    .mul_result (mul_result)
  );

  // Multiplier stand-in: exact products for the fixed vectors, a hash otherwise.
  function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40200000 && b == 32'h40A00000) return 32'h41480000;
    if (a == 32'h40400000 && b == 32'h40000000) return 32'h40C00000;
    return (a * 32'h9E3779B1) ^ {b[15:0], b[31:16]};
  endfunction

  assign mul_result = fmodel(mul_a, mul_b);

  int          n_checks = 0;
  int          n_pass   = 0;
  int          ops_left [NREQ];
  int          ops_idx  [NREQ];
  logic [31:0] a_tab [NREQ][4];
  logic [31:0] b_tab [NREQ][4];
  int          mul_lat = 2;
  int          hi_cnt = 0;
  int          starts = 0;
  logic        start_prev = 1'b0;
  int          exp_ptr = 0;
  logic [31:0] last_res = '0;

  int          ev_id [$];
  logic [31:0] ev_res [$];
  logic        ev_err [$];
  int          ev_hi [$];
  logic        ev_ms [$];
  logic        ev_busy [$];
  int          exp_ids [$];
  logic [31:0] exp_rs [$];

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (ops_left[i] > 0);
      if (ops_idx[i] < 4) begin
        req_a[i*32 +: 32] = a_tab[i][ops_idx[i]];
        req_b[i*32 +: 32] = b_tab[i][ops_idx[i]];
      end
    end
  endtask

  task automatic clear_ev();
    ev_id.delete(); ev_res.delete(); ev_err.delete();
    ev_hi.delete(); ev_ms.delete(); ev_busy.delete();
    starts = 0;
  endtask

  // One clock: sample at negedge, log acks, then update requesters and multiplier.
  task automatic step();
    int id;
    id = 0;
    @(negedge clk);
    if (mul_start && !start_prev) starts++;
    start_prev = mul_start;
    if (ack != '0) begin
      n_checks++;
      if ($countones(ack) != 1) $display("FAIL ack_onehot ack=%b required one-hot", ack);
      else n_pass++;
      for (int i = NREQ - 1; i >= 0; i--) if (ack[i]) id = i;
      ev_id.push_back(id); ev_res.push_back(rsp_result); ev_err.push_back(rsp_err);
      ev_hi.push_back(hi_cnt); ev_ms.push_back(mul_start); ev_busy.push_back(busy);
      $display("ack id=%0d result=%h err=%0d busy_cycles=%0d", id, rsp_result, rsp_err, hi_cnt);
      if (ops_left[id] > 0) begin
        ops_left[id]--;
        ops_idx[id]++;
      end
    end
    if (mul_start) hi_cnt++; else hi_cnt = 0;
    mul_done = {3'b000, (mul_start && hi_cnt == mul_lat + 1)};
    drive_reqs();
  endtask

  task automatic run_idle(input int budget, input string name);
    int c;
    bit all_done;
    for (c = 0; c < budget; c++) begin
      step();
      all_done = 1;
      for (int i = 0; i < NREQ; i++) if (ops_left[i] > 0) all_done = 0;
      if (all_done && !busy) break;
    end
    if (c >= budget) begin
      n_checks++;
      $display("FAIL %s_timeout cycles=%0d required completion within budget", name, c);
    end
  endtask

  // Reference arbitration: every requester with ops left is asking at each grant.
  task automatic build_expect();
    int rem [NREQ];
    int idx [NREQ];
    int j;
    bit found;
    exp_ids.delete(); exp_rs.delete();
    for (int i = 0; i < NREQ; i++) begin rem[i] = ops_left[i]; idx[i] = ops_idx[i]; end
    while (1) begin
      found = 0;
      j = 0;
      for (int k = 0; k < NREQ && !found; k++) begin
        j = (exp_ptr + k) % NREQ;
        if (rem[j] > 0) found = 1;
      end
      if (!found) break;
      exp_ids.push_back(j);
      exp_rs.push_back(fmodel(a_tab[j][idx[j]], b_tab[j][idx[j]]));
      rem[j]--; idx[j]++;
      exp_ptr = (j + 1) % NREQ;
    end
  endtask

  task automatic set_ops(input int o0, input int o1, input int o2, input int o3);
    ops_left = '{o0, o1, o2, o3};
    for (int i = 0; i < NREQ; i++) begin
      ops_idx[i] = 0;
      for (int k = 0; k < 4; k++) begin a_tab[i][k] = $urandom; b_tab[i][k] = $urandom; end
    end
  endtask

  task automatic do_reset();
    ops_left = '{0, 0, 0, 0};
    drive_reqs();
    @(negedge clk);
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    exp_ptr = 0;
    last_res = '0;
  endtask

  task automatic test_reset();
    ops_left = '{0, 0, 0, 0};
    drive_reqs();
    rst_n = 1'b0;
    step(); step();
    n_checks++; if (ack !== '0) $display("FAIL rst_ack got=%b required=0", ack); else n_pass++;
    n_checks++; if (rsp_result !== 32'h0) $display("FAIL rst_result got=%h required=0", rsp_result); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL rst_err got=%b required=0", rsp_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b required=0", busy); else n_pass++;
    n_checks++; if (mul_start !== 1'b0) $display("FAIL rst_start got=%b required=0", mul_start); else n_pass++;
    n_checks++; if ({mul_a, mul_b} !== 64'h0) $display("FAIL rst_operands got=%h_%h required=0", mul_a, mul_b); else n_pass++;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (busy !== 1'b0 || mul_start !== 1'b0) $display("FAIL idle_hold busy=%b start=%b required 0/0", busy, mul_start);
      else n_pass++;
    end
    $display("reset test done");
  endtask

  task automatic test_single();
    clear_ev();
    set_ops(1, 0, 0, 0);
    a_tab[0][0] = 32'h40200000; b_tab[0][0] = 32'h40A00000;
    mul_lat = 2;
    build_expect();
    drive_reqs();
    run_idle(100, "single");
    n_checks++; if (ev_id.size() != 1) $display("FAIL single_count got=%0d required=1", ev_id.size()); else n_pass++;
    if (ev_id.size() >= 1) begin
      n_checks++; if (ev_id[0] != 0) $display("FAIL single_id got=%0d required=0", ev_id[0]); else n_pass++;
      n_checks++; if (ev_res[0] !== 32'h41480000) $display("FAIL single_result got=%h required=41480000", ev_res[0]); else n_pass++;
      n_checks++; if (ev_err[0] !== 1'b0) $display("FAIL single_err got=%b required=0", ev_err[0]); else n_pass++;
      n_checks++; if (ev_hi[0] != 3) $display("FAIL single_latency got=%0d required=3", ev_hi[0]); else n_pass++;
      n_checks++; if (ev_ms[0] !== 1'b0 || ev_busy[0] !== 1'b1) $display("FAIL single_release start=%b busy=%b required 0/1", ev_ms[0], ev_busy[0]); else n_pass++;
    end
    n_checks++; if (starts != 1) $display("FAIL single_starts got=%0d required=1", starts); else n_pass++;
    last_res = 32'h41480000;
  endtask

  task automatic test_simultaneous();
    do_reset();
    n_checks++; if (rsp_result !== 32'h0 || mul_a !== 32'h0) $display("FAIL rerst_clear result=%h mul_a=%h required 0/0", rsp_result, mul_a); else n_pass++;
    clear_ev();
    set_ops(1, 1, 0, 0);
    a_tab[1][0] = 32'h40400000; b_tab[1][0] = 32'h40000000;
    mul_lat = 1;
    build_expect();
    drive_reqs();
    run_idle(100, "simul");
    n_checks++; if (ev_id.size() != 2) $display("FAIL simul_count got=%0d required=2", ev_id.size()); else n_pass++;
    if (ev_id.size() == 2) begin
      n_checks++; if (ev_id[0] != 0 || ev_id[1] != 1) $display("FAIL simul_order got=%0d,%0d required=0,1", ev_id[0], ev_id[1]); else n_pass++;
      n_checks++; if (ev_res[0] !== fmodel(a_tab[0][0], b_tab[0][0])) $display("FAIL simul_res0 got=%h required=%h", ev_res[0], fmodel(a_tab[0][0], b_tab[0][0])); else n_pass++;
      n_checks++; if (ev_res[1] !== 32'h40C00000) $display("FAIL simul_res1 got=%h required=40C00000", ev_res[1]); else n_pass++;
    end
    n_checks++; if (starts != 2) $display("FAIL simul_starts got=%0d required=2", starts); else n_pass++;
    last_res = 32'h40C00000;
  endtask

  task automatic test_fairness();
    int served [NREQ];
    do_reset();
    clear_ev();
    set_ops(3, 3, 3, 3);
    mul_lat = $urandom_range(0, 4);
    build_expect();
    drive_reqs();
    run_idle(400, "fair");
    served = '{0, 0, 0, 0};
    n_checks++; if (ev_id.size() != 12) $display("FAIL fair_count got=%0d required=12", ev_id.size()); else n_pass++;
    for (int k = 0; k < ev_id.size() && k < 12; k++) begin
      served[ev_id[k]]++;
      n_checks++;
      if (ev_id[k] != k % NREQ || ev_res[k] !== exp_rs[k])
        $display("FAIL fair_op%0d got id=%0d res=%h required id=%0d res=%h", k, ev_id[k], ev_res[k], k % NREQ, exp_rs[k]);
      else n_pass++;
    end
    for (int i = 0; i < NREQ; i++) begin
      n_checks++; if (served[i] != 3) $display("FAIL fair_served%0d got=%0d required=3", i, served[i]); else n_pass++;
    end
    n_checks++; if (starts != 12) $display("FAIL fair_starts got=%0d required=12", starts); else n_pass++;
    if (exp_rs.size() > 0) last_res = exp_rs[exp_rs.size()-1];
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      clear_ev();
      set_ops($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      mul_lat = $urandom_range(0, 5);
      build_expect();
      drive_reqs();
      run_idle(500, "random");
      n_checks++;
      if (ev_id.size() != exp_ids.size()) $display("FAIL rand%0d_count got=%0d required=%0d", r, ev_id.size(), exp_ids.size());
      else n_pass++;
      for (int k = 0; k < ev_id.size() && k < exp_ids.size(); k++) begin
        n_checks++;
        if (ev_id[k] != exp_ids[k] || ev_res[k] !== exp_rs[k] || ev_err[k] !== 1'b0)
          $display("FAIL rand%0d_op%0d got id=%0d res=%h err=%b required id=%0d res=%h err=0", r, k, ev_id[k], ev_res[k], ev_err[k], exp_ids[k], exp_rs[k]);
        else n_pass++;
      end
      if (exp_rs.size() > 0) last_res = exp_rs[exp_rs.size()-1];
    end
  endtask

  task automatic test_timeout();
    clear_ev();
    set_ops(0, 0, 1, 0);
    mul_lat = 1000;
    build_expect();
    drive_reqs();
    run_idle(100, "tmo");
    n_checks++; if (ev_id.size() != 1) $display("FAIL tmo_count got=%0d required=1", ev_id.size()); else n_pass++;
    if (ev_id.size() == 1) begin
      n_checks++; if (ev_id[0] != 2) $display("FAIL tmo_id got=%0d required=2", ev_id[0]); else n_pass++;
      n_checks++; if (ev_err[0] !== 1'b1) $display("FAIL tmo_err got=%b required=1", ev_err[0]); else n_pass++;
      n_checks++; if (ev_res[0] !== last_res) $display("FAIL tmo_result_hold got=%h required=%h", ev_res[0], last_res); else n_pass++;
      n_checks++; if (ev_hi[0] != TMO) $display("FAIL tmo_busy_cycles got=%0d required=%0d", ev_hi[0], TMO); else n_pass++;
      n_checks++; if (ev_ms[0] !== 1'b0) $display("FAIL tmo_start_drop got=%b required=0", ev_ms[0]); else n_pass++;
    end
  endtask

  task automatic test_coincide();
    clear_ev();
    set_ops(0, 0, 0, 1);
    mul_lat = TMO - 1;
    build_expect();
    drive_reqs();
    run_idle(100, "coinc");
    n_checks++; if (ev_id.size() != 1) $display("FAIL coinc_count got=%0d required=1", ev_id.size()); else n_pass++;
    if (ev_id.size() == 1) begin
      n_checks++; if (ev_err[0] !== 1'b0) $display("FAIL coinc_err got=%b required=0", ev_err[0]); else n_pass++;
      n_checks++; if (ev_res[0] !== exp_rs[0]) $display("FAIL coinc_result got=%h required=%h", ev_res[0], exp_rs[0]); else n_pass++;
      n_checks++; if (ev_hi[0] != TMO) $display("FAIL coinc_busy_cycles got=%0d required=%0d", ev_hi[0], TMO); else n_pass++;
    end
    last_res = exp_rs[0];
  endtask

  task automatic test_withdraw();
    logic [31:0] orig_a;
    logic [31:0] orig_b;
    int c;
    clear_ev();
    set_ops(0, 1, 0, 0);
    orig_a = a_tab[1][0]; orig_b = b_tab[1][0];
    mul_lat = 4;
    build_expect();
    drive_reqs();
    for (c = 0; c < 20 && !mul_start; c++) step();
    step();
    ops_left[1] = 0;
    a_tab[1][0] = ~orig_a; b_tab[1][0] = ~orig_b;
    drive_reqs();
    step();
    n_checks++; if (mul_a !== orig_a || mul_b !== orig_b) $display("FAIL wd_operand_hold got=%h_%h required=%h_%h", mul_a, mul_b, orig_a, orig_b); else n_pass++;
    for (c = 0; c < 40 && ev_id.size() == 0; c++) step();
    n_checks++; if (ev_id.size() != 1) $display("FAIL wd_count got=%0d required=1", ev_id.size()); else n_pass++;
    if (ev_id.size() == 1) begin
      n_checks++;
      if (ev_id[0] != 1 || ev_res[0] !== fmodel(orig_a, orig_b) || ev_err[0] !== 1'b0)
        $display("FAIL wd_ack got id=%0d res=%h err=%b required id=1 res=%h err=0", ev_id[0], ev_res[0], ev_err[0], fmodel(orig_a, orig_b));
      else n_pass++;
    end
    step(); step();
    last_res = fmodel(orig_a, orig_b);
  endtask

  task automatic test_reset_mid();
    int nev;
    int c;
    clear_ev();
    set_ops(1, 0, 0, 0);
    mul_lat = 1000;
    drive_reqs();
    for (c = 0; c < 20 && !mul_start; c++) step();
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (mul_start !== 1'b0 || busy !== 1'b0) $display("FAIL mid_rst_drop start=%b busy=%b required 0/0", mul_start, busy); else n_pass++;
    n_checks++; if (mul_a !== 32'h0 || rsp_result !== 32'h0 || ack !== '0) $display("FAIL mid_rst_clear mul_a=%h result=%h ack=%b required 0", mul_a, rsp_result, ack); else n_pass++;
    nev = ev_id.size();
    mul_lat = 2;
    for (c = 0; c < 2; c++) begin
      step();
      n_checks++; if (mul_start !== 1'b0) $display("FAIL mid_rst_hold start=%b required=0", mul_start); else n_pass++;
    end
    rst_n = 1'b1;
    exp_ptr = 0;
    n_checks++; if (ev_id.size() != nev) $display("FAIL mid_rst_noack got=%0d required=%0d", ev_id.size(), nev); else n_pass++;
    build_expect();
    run_idle(100, "mid_rst");
    n_checks++; if (ev_id.size() != 1) $display("FAIL mid_rst_count got=%0d required=1", ev_id.size()); else n_pass++;
    if (ev_id.size() == 1) begin
      n_checks++;
      if (ev_id[0] != 0 || ev_res[0] !== exp_rs[0] || ev_err[0] !== 1'b0)
        $display("FAIL mid_rst_after got id=%0d res=%h err=%b required id=0 res=%h err=0", ev_id[0], ev_res[0], ev_err[0], exp_rs[0]);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      ops_left[i] = 0; ops_idx[i] = 0;
      for (int k = 0; k < 4; k++) begin a_tab[i][k] = '0; b_tab[i][k] = '0; end
    end
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_random();
    test_timeout();
    test_coincide();
    test_withdraw();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fmul_share_arb.md
FMUL_SHARE_ARB -- requirements
Module: fmul_share_arb

Interface
REQ-001 Parameter NREQ, default 4; number of requesters sharing one multiplier (2..8).
REQ-002 Parameter TIMEOUT, default 255; maximum BUSY cycles before abort (1..65535).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NREQ  per-requester request level; held high until the matching ack.
REQ-006 req_a  input  NREQ*32  per-requester IEEE-754 single operand A, slice i = bits [32i+31:32i].
REQ-007 req_b  input  NREQ*32  per-requester operand B, same slicing as req_a.
REQ-008 ack  output  NREQ  one-cycle completion pulse to the served requester.
REQ-009 rsp_result  output  32  product for the acked requester; valid while ack pulses, held until the next ack.
REQ-010 rsp_err  output  1  high with ack when the operation timed out.
REQ-011 busy  output  1  high while an operation is in flight.
REQ-012 mul_a, mul_b  output  32 each  operands to the multiplier.
REQ-013 mul_start  output  1  multiplier start level.
REQ-014 mul_done  input  4  multiplier done flags; only bit 0 is significant.
REQ-015 mul_result  input  32  multiplier product.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY and RELEASE.
REQ-017 In IDLE with any req bit high, the block SHALL grant the first high bit at or after rr_ptr, wrapping modulo NREQ, latch that requester's A/B into mul_a/mul_b and its index into cur_id, set mul_start=1, clear the timer and enter BUSY on the same edge.
REQ-018 In IDLE with req==0, all outputs SHALL hold and busy SHALL be 0.
REQ-019 In BUSY, mul_start and mul_a/mul_b SHALL hold constant, and the timer SHALL increment every cycle.
REQ-020 In BUSY, when mul_done[0]==1 is sampled, the block SHALL capture mul_result into rsp_result, pulse ack[cur_id] for one cycle with rsp_err=0, drop mul_start, and enter RELEASE on the same edge.
REQ-021 In BUSY, when the timer reaches TIMEOUT with no done, the block SHALL pulse ack[cur_id] with rsp_err=1, keep the previous rsp_result, drop mul_start and enter RELEASE.
REQ-022 If done and timeout occur in the same cycle, done SHALL win and rsp_err SHALL be 0.
REQ-023 RELEASE SHALL last exactly one cycle, with mul_start=0, ack=0 and rr_ptr=(cur_id+1) mod NREQ, then return to IDLE.
REQ-024 Latency SHALL be as follows: grant edge to mul_start high = 0 cycles; done sampled to ack = 1 edge; minimum spacing between two grants = 2 cycles after the ack.
REQ-025 Changes to req or operands after grant SHALL NOT affect the in-flight operation; a withdrawn request SHALL still complete and receive its ack.
REQ-026 A req still high in the cycle after its ack SHALL be treated as a new request and arbitrated fairly under the advanced rr_ptr.
REQ-027 busy SHALL be 1 in BUSY and RELEASE.
REQ-028 The ack bus SHALL be one-hot or zero.

Reset
REQ-029 While rst_n=0, the block SHALL force state=IDLE, rr_ptr=0, cur_id=0, timer=0, ack=0, rsp_result=0, rsp_err=0, busy=0, mul_start=0, mul_a=0 and mul_b=0.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no ack issued, and mul_start SHALL fall immediately.
REQ-031 Leaving reset, the first grant SHALL occur no earlier than the first rising edge with rst_n=1.

Structure
REQ-032 State encodings and the default TIMEOUT SHALL live in the shared package fmul_pkg.
REQ-033 A single sub-module rr_pick (NREQ-wide rotate, priority find, rotate back, combinational) SHALL be used for grant selection.
REQ-034 The multiplier SHALL be instantiated outside this block, at the level above.

Verification
REQ-035 Single request: req0, A=0x40200000 (2.5), B=0x40A00000 (5.0) -> one ack[0] pulse, rsp_result=0x41480000, rsp_err=0.
REQ-036 Simultaneous requests: req0 and req1 asserted in the same cycle with rr_ptr=0, req1 A=0x40400000, B=0x40000000 -> ack[0] first, then ack[1] with 0x40C00000, exactly one mul_start rising edge per ack.
REQ-037 Fairness: all four reqs held high for 12 operations -> ack order 0,1,2,3,0,1,... and each requester served 3 times.
REQ-038 Timeout: multiplier model never raises done, TIMEOUT=8 -> ack with rsp_err=1 after 8 BUSY cycles, then mul_start low for 1 cycle.
REQ-039 Done and timeout coincide: done arrives on the TIMEOUT cycle -> rsp_err=0 and rsp_result=mul_result.
REQ-040 Reset mid-operation: rst_n pulled low during BUSY -> mul_start=0 immediately, no ack, next request served normally.
